out_wbuffer: RTL

OUT_WBUFFER -- requirements
Module: out_wbuffer

---
 rtl/out_wbuffer_pkg.sv | 26 ++
 rtl/wbuf_rowfile.sv | 38 +++
 rtl/out_wbuffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/out_wbuffer_pkg.sv
// Shared definitions for the output write buffer and the output stage that
// consumes it: row geometry, memory depth and the buffer state encoding.
package out_wbuffer_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int DEPTH  = 16;
  localparam int ROW_W  = LANES * LANE_W;
  localparam int SLOTS  = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_COLLECT,
    ST_HOLD,
    ST_STORE,
    ST_DONE
  } wb_state_e;

  // A tile holds 1..4 rows; 0 encodes a full tile. Codes above 4 cannot be
  // held in the slot file and are treated as a full tile as well.
  function automatic logic [2:0] row_total_map(input logic [2:0] t);
    return ((t == 3'd0) || (t > 3'd4)) ? 3'd4 : t;
  endfunction

endpackage

// File: rtl/wbuf_rowfile.sv
// Four-slot row storage for one tile plus the per-lane accumulate adder used
// on the write side of the read-modify-write.
module wbuf_rowfile #(
  parameter int LANES  = out_wbuffer_pkg::LANES,
  parameter int LANE_W = out_wbuffer_pkg::LANE_W
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    wr_en,
  input  logic [1:0]              wr_idx,
  input  logic [LANES*LANE_W-1:0] wr_data,
  input  logic                    clr,
  input  logic [1:0]              rd_idx,
  input  logic [LANES*LANE_W-1:0] mem_rdata,
  output logic [LANES*LANE_W-1:0] sum
);
  import out_wbuffer_pkg::*;

  logic [LANES*LANE_W-1:0] slot [SLOTS];

  // Slot storage: cleared on reset and after each completed tile.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
    end else if (wr_en) begin
      slot[wr_idx] <= wr_data;
    end
  end

  // Independent lane adders: each lane wraps modulo 2^LANE_W, no cross-lane carry.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign sum[k*LANE_W +: LANE_W] = mem_rdata[k*LANE_W +: LANE_W]
                                   + slot[rd_idx][k*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/out_wbuffer.sv
// Output write buffer: clears the output memory after reset, collects the
// rows of one tile, then accumulates them into memory with a pipelined
// read-modify-write once the memory bus is granted.
module out_wbuffer #(
  parameter int LANES  = out_wbuffer_pkg::LANES,
  parameter int LANE_W = out_wbuffer_pkg::LANE_W,
  parameter int DEPTH  = out_wbuffer_pkg::DEPTH
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       ROW_VALID,
  input  logic [LANES*LANE_W-1:0]    ROW_DATA,
  input  logic [2:0]                 ROW_TOTAL,
  input  logic                       ACC,
  input  logic [3:0]                 ODST,
  input  logic                       OMSRC,
  output logic [$clog2(DEPTH)-1:0]   MEM_RADDR,
  output logic                       MEM_RE,
  input  logic [LANES*LANE_W-1:0]    MEM_RDATA,
  output logic [$clog2(DEPTH)-1:0]   MEM_WADDR,
  output logic                       MEM_WE,
  output logic [LANES*LANE_W-1:0]    MEM_WDATA,
  output logic                       LOAD_DONE,
  output logic                       STORE_DONE,
  output logic                       INIT_DONE,
  output logic                       OVF
);
  import out_wbuffer_pkg::*;

  localparam int AW = $clog2(DEPTH);

  wb_state_e               state;
  logic [AW:0]             icnt;       // top bit set once all DEPTH entries are cleared (DEPTH is a power of two)
  logic [2:0]              total;
  logic [2:0]              rc;
  logic [AW-1:0]           base;
  logic [2:0]              s;          // STORE cycle index, 0..total
  logic                    re_p0;
  logic [AW-1:0]           raddr_p0;
  logic                    we_p1;
  logic [AW-1:0]           waddr_p1;
  logic [1:0]              widx_p1;
  logic                    load_done;
  logic                    store_done;
  logic                    init_done;
  logic                    ovf;
  logic                    row_wr;
  logic [LANES*LANE_W-1:0] sum;
  logic                    unused_odst;

  assign unused_odst = ^ODST[1:0];
  assign row_wr      = (state == ST_COLLECT) && ROW_VALID && ACC;

  wbuf_rowfile #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_rowfile (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .wr_en     (row_wr),
    .wr_idx    (rc[1:0]),
    .wr_data   (ROW_DATA),
    .clr       (state == ST_DONE),
    .rd_idx    (widx_p1),
    .mem_rdata (MEM_RDATA),
    .sum       (sum)
  );

  // Control FSM with registered memory strobes and status pulses.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_INIT;
      icnt       <= '0;
      total      <= 3'd4;
      rc         <= '0;
      base       <= '0;
      s          <= '0;
      re_p0      <= 1'b0;
      raddr_p0   <= '0;
      we_p1      <= 1'b0;
      waddr_p1   <= '0;
      widx_p1    <= '0;
      load_done  <= 1'b0;
      store_done <= 1'b0;
      init_done  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      load_done  <= 1'b0;
      store_done <= 1'b0;
      we_p1      <= 1'b0;
      re_p0      <= 1'b0;
      if (ROW_VALID && ((state == ST_HOLD) || (state == ST_STORE) || (state == ST_DONE)))
        ovf <= 1'b1;
      case (state)
        ST_INIT: begin
          if (!icnt[AW]) begin
            we_p1    <= 1'b1;
            waddr_p1 <= icnt[AW-1:0];
            icnt     <= icnt + 1'b1;
          end else begin
            init_done <= 1'b1;
            total     <= row_total_map(ROW_TOTAL);
            rc        <= '0;
            state     <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (ROW_VALID && ACC) begin
            rc <= rc + 3'd1;
            if (rc == 3'd0) base <= AW'({ODST[3:2], 2'b00});
            if ((rc + 3'd1) == total) begin
              load_done <= 1'b1;
              state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (OMSRC) begin
            re_p0    <= 1'b1;
            raddr_p0 <= base;
            s        <= '0;
            state    <= ST_STORE;
          end
        end
        ST_STORE: begin
          // --- stage p0 (read row s) -> stage p1 (write row s) ---
          if (s < total) begin
            we_p1    <= 1'b1;
            waddr_p1 <= base + AW'(s);
            widx_p1  <= s[1:0];
            re_p0    <= ((s + 3'd1) < total);
            raddr_p0 <= base + AW'(s + 3'd1);
            s        <= s + 3'd1;
          end else begin
            store_done <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          total <= row_total_map(ROW_TOTAL);
          rc    <= '0;
          state <= ST_COLLECT;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign MEM_RE     = re_p0;
  assign MEM_RADDR  = raddr_p0;
  assign MEM_WE     = we_p1;
  assign MEM_WADDR  = waddr_p1;
  assign MEM_WDATA  = (state == ST_STORE) ? sum : '0;
  assign LOAD_DONE  = load_done;
  assign STORE_DONE = store_done;
  assign INIT_DONE  = init_done;
  assign OVF        = ovf;

endmodule
